compute_inst_encoder: RTL and testbench

Builds 128-bit compute-queue instructions from typed requests and issues them to the compute instruction queue. It is the encoder counterpart to the compute decoder, and its output bit layout must round-trip through that decoder exactly. It sits between the host-side command sequencer and the compute module's instruction FIFO. It includes a 2-entry output buffer, a run/drain/done sequencer keyed on FINISH, and issue/error counters.

---
 rtl/compute_isa_pkg.sv | 108 ++++++++++
 rtl/compute_inst_encoder_if.sv | 31 +++
 rtl/inst_fifo.sv | 64 ++++++
 rtl/compute_inst_encoder.sv | 95 +++++++++
 tb/tb_compute_inst_encoder.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/compute_isa_pkg.sv
// -----------------------------------------------------------------------------
// compute_isa_pkg
// Shared definitions for the compute instruction queue: opcode and memId
// constants, request-kind and ALU-op enums, instruction field positions, and
// helpers that classify and build a 128-bit compute instruction.
// Used by both the compute encoder and the compute decoder so that the two
// always agree on the bit layout.
// -----------------------------------------------------------------------------
package compute_isa_pkg;

    localparam int INST_W = 128;

    // Opcodes, field [2:0]
    localparam logic [2:0] OP_LOAD   = 3'd0;
    localparam logic [2:0] OP_STORE  = 3'd1;
    localparam logic [2:0] OP_GEMM   = 3'd2;
    localparam logic [2:0] OP_FINISH = 3'd3;
    localparam logic [2:0] OP_ALU    = 3'd4;

    // Memory identifiers, field [9:7]
    localparam logic [2:0] MEM_UOP = 3'd0;
    localparam logic [2:0] MEM_ACC = 3'd3;

    // Field positions
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 3;
    localparam int DEPS_LSB   = 3;   // {push_next, push_prev, pop_next, pop_prev}
    localparam int DEPS_W     = 4;
    localparam int MEMID_LSB  = 7;
    localparam int MEMID_W    = 3;
    localparam int XSIZE_LSB  = 80;
    localparam int XSIZE_W    = 16;
    localparam int ALUOP_LSB  = 108;
    localparam int ALUOP_W    = 3;

    // Request kinds; 6 and 7 are illegal encodings
    typedef enum logic [2:0] {
        KIND_LOAD_UOP = 3'd0,
        KIND_LOAD_ACC = 3'd1,
        KIND_SYNC     = 3'd2,
        KIND_GEMM     = 3'd3,
        KIND_ALU      = 3'd4,
        KIND_FINISH   = 3'd5
    } reqKind_t;

    typedef enum logic [2:0] {
        ALU_MIN = 3'd0,
        ALU_MAX = 3'd1,
        ALU_ADD = 3'd2,
        ALU_SHR = 3'd3
    } aluOp_t;

    // A load with nothing to move, an unknown ALU op or an unknown kind is
    // not worth sending downstream.
    function automatic logic isLegalReq(input logic [2:0]  kind,
                                        input logic [15:0] xsize,
                                        input logic [2:0]  aluOp);
        logic legal;
        case (kind)
            KIND_LOAD_UOP,
            KIND_LOAD_ACC: legal = (xsize != 16'd0);
            KIND_SYNC,
            KIND_GEMM,
            KIND_FINISH:   legal = 1'b1;
            KIND_ALU:      legal = (aluOp <= ALU_SHR);
            default:       legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Overlay the owned fields on the caller-supplied body.
    // SYNC is a zero-length UOP load, hence its forced xsize of 0.
    function automatic logic [INST_W-1:0] encodeInst(input logic [2:0]        kind,
                                                     input logic [3:0]        deps,
                                                     input logic [15:0]       xsize,
                                                     input logic [2:0]        aluOp,
                                                     input logic [INST_W-1:0] body);
        logic [INST_W-1:0] inst;
        inst = body;
        inst[DEPS_LSB +: DEPS_W] = deps;
        case (kind)
            KIND_LOAD_UOP: begin
                inst[OPCODE_LSB +: OPCODE_W] = OP_LOAD;
                inst[MEMID_LSB +: MEMID_W]   = MEM_UOP;
                inst[XSIZE_LSB +: XSIZE_W]   = xsize;
            end
            KIND_LOAD_ACC: begin
                inst[OPCODE_LSB +: OPCODE_W] = OP_LOAD;
                inst[MEMID_LSB +: MEMID_W]   = MEM_ACC;
                inst[XSIZE_LSB +: XSIZE_W]   = xsize;
            end
            KIND_SYNC: begin
                inst[OPCODE_LSB +: OPCODE_W] = OP_LOAD;
                inst[MEMID_LSB +: MEMID_W]   = MEM_UOP;
                inst[XSIZE_LSB +: XSIZE_W]   = 16'd0;
            end
            KIND_GEMM:   inst[OPCODE_LSB +: OPCODE_W] = OP_GEMM;
            KIND_ALU: begin
                inst[OPCODE_LSB +: OPCODE_W] = OP_ALU;
                inst[ALUOP_LSB +: ALUOP_W]   = aluOp;
            end
            KIND_FINISH: inst[OPCODE_LSB +: OPCODE_W] = OP_FINISH;
            default: ;
        endcase
        return inst;
    endfunction

endpackage

// File: rtl/compute_inst_encoder_if.sv
// -----------------------------------------------------------------------------
// compute_inst_encoder_if
// Request channel (sequencer -> encoder) and instruction channel
// (encoder -> compute instruction FIFO), both valid/ready.
//   slave  : encoder view (consumes requests, produces instructions)
//   master : environment view (produces requests, consumes instructions)
// -----------------------------------------------------------------------------
interface compute_inst_encoder_if;
    logic         io_req_valid;
    logic         io_req_ready;
    logic [2:0]   io_req_kind;
    logic [3:0]   io_req_deps;
    logic [15:0]  io_req_xsize;
    logic [2:0]   io_req_alu_op;
    logic [127:0] io_req_body;
    logic         io_out_valid;
    logic         io_out_ready;
    logic [127:0] io_out_inst;

    modport slave (
        input  io_req_valid, io_req_kind, io_req_deps, io_req_xsize,
               io_req_alu_op, io_req_body, io_out_ready,
        output io_req_ready, io_out_valid, io_out_inst
    );

    modport master (
        output io_req_valid, io_req_kind, io_req_deps, io_req_xsize,
               io_req_alu_op, io_req_body, io_out_ready,
        input  io_req_ready, io_out_valid, io_out_inst
    );
endinterface

// File: rtl/inst_fifo.sv
// -----------------------------------------------------------------------------
// inst_fifo
// Generic DEPTH x WIDTH synchronous FIFO, valid/ready on both sides.
//   clock, reset      : clock, synchronous active-high reset
//   inValid/inReady   : write side; inReady depends only on occupancy
//   inData            : write data
//   outValid/outReady : read side; outData is the head entry
//   count             : current occupancy (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module inst_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 128
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       inValid,
    output logic                       inReady,
    input  logic [WIDTH-1:0]           inData,
    output logic                       outValid,
    input  logic                       outReady,
    output logic [WIDTH-1:0]           outData,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_B = PTR_W + 1;
    localparam logic [CNT_B-1:0] FULL = CNT_B'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic             push, pop;

    // Full means not ready, even if the head leaves this same cycle.
    assign inReady  = (count < FULL);
    assign outValid = (count != '0);
    assign push     = inValid && inReady;
    assign pop      = outValid && outReady;
    // Empty reads as zero so stale storage never shows on the output.
    assign outData  = outValid ? mem[rdPtr] : '0;

    // NOTE: storage is deliberately not reset; pointers/count define what is
    // valid, and the empty-gate above keeps the output clean after reset.
    always_ff @(posedge clock) begin
        if (push) mem[wrPtr] <= inData;
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_B'(1);
                2'b01:   count <= count - CNT_B'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/compute_inst_encoder.sv
// -----------------------------------------------------------------------------
// compute_inst_encoder
// Turns typed requests into 128-bit compute instructions and queues them for
// the compute instruction FIFO. Illegal requests are handshaken and dropped.
// A run/drain/done sequencer stops intake after FINISH until restarted.
//   clock, reset : clock, synchronous active-high reset
//   bus (slave)  : request channel in, instruction channel out
//   io_restart   : one-cycle pulse, leaves DONE (ignored elsewhere)
//   io_done      : high while in DONE
//   io_err       : one-cycle pulse the cycle after a dropped request
//   io_issued    : instructions taken by downstream (wraps)
//   io_errors    : dropped requests (wraps)
// -----------------------------------------------------------------------------
module compute_inst_encoder
    import compute_isa_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    compute_inst_encoder_if.slave bus,
    input  logic                 io_restart,
    output logic                 io_done,
    output logic                 io_err,
    output logic [CNT_W-1:0]     io_issued,
    output logic [CNT_W-1:0]     io_errors
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } seqState_t;

    seqState_t             stateQ, stateD;
    logic                  fifoInReady;
    logic [$clog2(DEPTH):0] fifoCount;
    logic                  reqFire, reqLegal, outFire;
    logic [INST_W-1:0]     encoded;

    assign reqLegal = isLegalReq(bus.io_req_kind, bus.io_req_xsize, bus.io_req_alu_op);
    assign encoded  = encodeInst(bus.io_req_kind, bus.io_req_deps, bus.io_req_xsize,
                                 bus.io_req_alu_op, bus.io_req_body);

    assign bus.io_req_ready = (stateQ == ST_RUN) && fifoInReady;
    assign reqFire          = bus.io_req_valid && bus.io_req_ready;
    assign outFire          = bus.io_out_valid && bus.io_out_ready;
    assign io_done          = (stateQ == ST_DONE);

    // The FIFO output is the registered instruction: no request-to-output path.
    inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INST_W)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .inValid  (reqFire && reqLegal),
        .inReady  (fifoInReady),
        .inData   (encoded),
        .outValid (bus.io_out_valid),
        .outReady (bus.io_out_ready),
        .outData  (bus.io_out_inst),
        .count    (fifoCount)
    );

    always_ff @(posedge clock) begin
        if (reset) stateQ <= ST_RUN;
        else       stateQ <= stateD;
    end

    // NOTE: next state defaults to the current state before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            ST_RUN:   if (reqFire && reqLegal && (bus.io_req_kind == KIND_FINISH))
                          stateD = ST_DRAIN;
            ST_DRAIN: if (fifoCount == '0) stateD = ST_DONE;
            ST_DONE:  if (io_restart) stateD = ST_RUN;
            default:  stateD = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            io_err    <= 1'b0;
            io_errors <= '0;
            io_issued <= '0;
        end else begin
            io_err <= reqFire && !reqLegal;
            if (reqFire && !reqLegal) io_errors <= io_errors + CNT_W'(1);
            if (outFire)              io_issued <= io_issued + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_compute_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_compute_inst_encoder
// Directed vectors with hand-computed expected instructions for the compute
// instruction encoder: per-kind encoding, drop rules, back-pressure, the
// FINISH drain sequence and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_compute_inst_encoder;
    import compute_isa_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_restart;
    logic        io_done;
    logic        io_err;
    logic [31:0] io_issued;
    logic [31:0] io_errors;

    int passCount  = 0;
    int checkCount = 0;

    compute_inst_encoder_if bus ();

    compute_inst_encoder #(
        .DEPTH (2),
        .CNT_W (32)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .io_restart (io_restart),
        .io_done    (io_done),
        .io_err     (io_err),
        .io_issued  (io_issued),
        .io_errors  (io_errors)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idleReq();
        bus.io_req_valid  = 1'b0;
        bus.io_req_kind   = 3'd0;
        bus.io_req_deps   = 4'd0;
        bus.io_req_xsize  = 16'd0;
        bus.io_req_alu_op = 3'd0;
        bus.io_req_body   = '0;
    endtask

    task automatic drive(input logic [2:0] kind, input logic [3:0] deps, input logic [15:0] xsize,
                         input logic [2:0] aluOp, input logic [127:0] body);
        bus.io_req_valid  = 1'b1;
        bus.io_req_kind   = kind;
        bus.io_req_deps   = deps;
        bus.io_req_xsize  = xsize;
        bus.io_req_alu_op = aluOp;
        bus.io_req_body   = body;
    endtask

    // Present a request, wait (bounded) for ready, take the edge, then withdraw.
    task automatic sendOne(input logic [2:0] kind, input logic [3:0] deps, input logic [15:0] xsize,
                           input logic [2:0] aluOp, input logic [127:0] body);
        bit accepted = 0;
        drive(kind, deps, xsize, aluOp, body);
        for (int i = 0; i < 20; i++) begin
            if (bus.io_req_ready === 1'b1) begin
                accepted = 1;
                break;
            end
            step();
        end
        if (!accepted) check("req_ready_timeout", 128'd0, 128'd1);
        step();
        bus.io_req_valid = 1'b0;
    endtask

    // Reference decoder view: {isLoadUop, isLoadAcc, isSync, push_next, push_prev, pop_next, pop_prev}
    function automatic logic [6:0] decodeFlags(input logic [127:0] inst);
        logic [2:0]  op;
        logic [2:0]  mem;
        logic [15:0] xs;
        op  = inst[2:0];
        mem = inst[9:7];
        xs  = inst[95:80];
        return {(op == 3'd0) && (mem == 3'd0) && (xs != 16'd0),
                (op == 3'd0) && (mem == 3'd3) && (xs != 16'd0),
                (op == 3'd0) && (xs == 16'd0),
                inst[6:3]};
    endfunction

    initial begin
        reset      = 1'b1;
        io_restart = 1'b0;
        bus.io_out_ready = 1'b1;
        idleReq();
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_out_valid", bus.io_out_valid, 1'b0);
        check("rst_out_inst",  bus.io_out_inst,  128'd0);
        check("rst_err",       io_err,           1'b0);
        check("rst_done",      io_done,          1'b0);
        check("rst_issued",    io_issued,        32'd0);
        check("rst_errors",    io_errors,        32'd0);
        check("rst_req_ready", bus.io_req_ready, 1'b1);

        // LOAD_ACC, push_next, xsize 0x10
        sendOne(KIND_LOAD_ACC, 4'b1000, 16'h0010, 3'd0, 128'd0);
        check("ld_acc_valid", bus.io_out_valid, 1'b1);
        check("ld_acc_inst",  bus.io_out_inst,  128'h00000000_00100000_00000000_000001C0);
        check("ld_acc_flags", 7'(decodeFlags(bus.io_out_inst)), 7'b010_1000);
        step();

        // SYNC forces xsize to zero
        sendOne(KIND_SYNC, 4'b0000, 16'h0005, 3'd0, 128'd0);
        check("sync_valid", bus.io_out_valid, 1'b1);
        check("sync_inst",  bus.io_out_inst,  128'd0);
        check("sync_flags", 7'(decodeFlags(bus.io_out_inst)), 7'b001_0000);
        step();

        // LOAD_UOP over an all-ones body: only owned fields change
        sendOne(KIND_LOAD_UOP, 4'b0101, 16'h1234, 3'd0, {128{1'b1}});
        check("ld_uop_inst", bus.io_out_inst, 128'hFFFFFFFF_1234FFFF_FFFFFFFF_FFFFFC28);
        step();

        // ALU ADD
        sendOne(KIND_ALU, 4'b0000, 16'h0000, 3'd2, 128'd0);
        check("alu_add_inst", bus.io_out_inst, 128'h00002000_00000000_00000000_00000004);
        step();

        // ALU MIN over all-ones body: memId and xsize are not owned for ALU
        sendOne(KIND_ALU, 4'b0000, 16'h0000, 3'd0, {128{1'b1}});
        check("alu_min_inst", bus.io_out_inst, 128'hFFFF8FFF_FFFFFFFF_FFFFFFFF_FFFFFF84);
        step();

        // Drops: ALU op 5, kind 7, LOAD_UOP with xsize 0
        sendOne(KIND_ALU, 4'b0000, 16'h0000, 3'd5, 128'd0);
        check("drop_alu_valid",  bus.io_out_valid, 1'b0);
        check("drop_alu_err",    io_err,           1'b1);
        check("drop_alu_errors", io_errors,        32'd1);
        step();
        check("drop_alu_err_pulse", io_err, 1'b0);

        sendOne(3'd7, 4'b0000, 16'h0010, 3'd0, 128'd0);
        check("drop_k7_valid",  bus.io_out_valid, 1'b0);
        check("drop_k7_err",    io_err,           1'b1);
        check("drop_k7_errors", io_errors,        32'd2);
        step();

        sendOne(KIND_LOAD_UOP, 4'b0000, 16'h0000, 3'd0, 128'd0);
        check("drop_x0_valid",  bus.io_out_valid, 1'b0);
        check("drop_x0_errors", io_errors,        32'd3);
        step();
        check("cnt_issued_5", io_issued, 32'd5);

        // Reset clears counters before the back-pressure run
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst2_issued", io_issued, 32'd0);
        check("rst2_errors", io_errors, 32'd0);

        // Back-pressure: three GEMMs with out_ready low, tagged via body
        bus.io_out_ready = 1'b0;
        drive(KIND_GEMM, 4'd0, 16'd0, 3'd0, 128'hA0010000_00000000_00000000_00000000);
        check("bp_ready_e0", bus.io_req_ready, 1'b1);
        step();
        bus.io_req_body = 128'hA0020000_00000000_00000000_00000000;
        check("bp_ready_e1", bus.io_req_ready, 1'b1);
        step();
        bus.io_req_body = 128'hA0030000_00000000_00000000_00000000;
        check("bp_full_ready", bus.io_req_ready, 1'b0);
        check("bp_full_valid", bus.io_out_valid, 1'b1);
        check("bp_head_1",     bus.io_out_inst,  128'hA0010000_00000000_00000000_00000002);
        step();
        check("bp_hold_ready", bus.io_req_ready, 1'b0);
        check("bp_hold_inst",  bus.io_out_inst,  128'hA0010000_00000000_00000000_00000002);
        bus.io_out_ready = 1'b1;
        step();
        check("bp_reopen_ready", bus.io_req_ready, 1'b1);
        check("bp_head_2",       bus.io_out_inst,  128'hA0020000_00000000_00000000_00000002);
        step();
        bus.io_req_valid = 1'b0;
        check("bp_head_3_valid", bus.io_out_valid, 1'b1);
        check("bp_head_3",       bus.io_out_inst,  128'hA0030000_00000000_00000000_00000002);
        step();
        check("bp_empty",  bus.io_out_valid, 1'b0);
        check("bp_issued", io_issued,        32'd3);

        // FINISH behind one buffered GEMM
        bus.io_out_ready = 1'b0;
        drive(KIND_GEMM, 4'd0, 16'd0, 3'd0, 128'hB0000000_00000000_00000000_00000000);
        step();
        check("fin_gemm_first", bus.io_out_inst, 128'hB0000000_00000000_00000000_00000002);
        drive(KIND_FINISH, 4'd0, 16'd0, 3'd0, 128'd0);
        bus.io_out_ready = 1'b1;
        step();
        idleReq();
        check("fin_inst",        bus.io_out_inst,  128'h3);
        check("fin_valid",       bus.io_out_valid, 1'b1);
        check("drain_req_ready", bus.io_req_ready, 1'b0);
        check("drain_done",      io_done,          1'b0);
        io_restart = 1'b1;
        step();
        io_restart = 1'b0;
        check("drain_empty",          bus.io_out_valid, 1'b0);
        check("drain_restart_ignored", bus.io_req_ready, 1'b0);
        check("drain_done_empty",     io_done,          1'b0);
        step();
        check("done_flag",      io_done,          1'b1);
        check("done_req_ready", bus.io_req_ready, 1'b0);
        drive(KIND_GEMM, 4'd0, 16'd0, 3'd0, 128'd0);
        step();
        idleReq();
        check("done_refused", bus.io_out_valid, 1'b0);
        io_restart = 1'b1;
        step();
        io_restart = 1'b0;
        check("restart_ready", bus.io_req_ready, 1'b1);
        check("restart_done",  io_done,          1'b0);
        check("fin_issued",    io_issued,        32'd5);

        // Mid-stream reset discards buffered instructions
        bus.io_out_ready = 1'b0;
        sendOne(KIND_GEMM, 4'd0, 16'd0, 3'd0, 128'd0);
        sendOne(KIND_GEMM, 4'd0, 16'd0, 3'd0, 128'd0);
        check("mid_full", bus.io_out_valid, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_valid",  bus.io_out_valid, 1'b0);
        check("mid_rst_inst",   bus.io_out_inst,  128'd0);
        check("mid_rst_issued", io_issued,        32'd0);
        check("mid_rst_errors", io_errors,        32'd0);
        bus.io_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_no_emit", bus.io_out_valid, 1'b0);
        end
        check("mid_final_issued", io_issued, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
